column_scan_driver: RTL and testbench

Downstream display stage of the digital LED panel: takes the 5-row × 7-column frame produced by the universal registers and drives the physical matrix by time-multiplexed column scanning. It replaces the loose divider/counter/decoder/row-MUX chain with one registered block: per-frame double buffering, one-hot column drive, an optional anti-ghosting blank gap between columns, and a frame-start strobe that tells upstream scroll logic when it may shift.

---
 rtl/column_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_column_scan_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/column_scan_driver.sv
// column_scan_driver
// Drives the 5x7 LED matrix by scanning one column at a time. A full
// frame is latched once per scan, so upstream changes never tear a frame
// that is already on the panel. The columns are lit one at a time,
// left to right.
//
// Optional feature macro: SCAN_BLANK_EN
//   defined   : every lit column is followed by BLANK_CYCLES all-off cycles,
//               which suppresses ghosting on the panel.
//   undefined : the columns follow each other with no gap.
//
// Parameters:
//   DIV          clk cycles each column stays lit (>= 1)
//   BLANK_CYCLES clk cycles of all-off gap after a column (>= 1, macro only)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   enable       scan enable; low blanks the panel and abandons the scan
//   frame[34:0]  display data, bit r*7+c = row r, column c
//   L[4:0]       row drive, active-high
//   C[6:0]       column drive, one-hot active-high
//   col_idx[2:0] current column index
//   frame_start  one-cycle pulse in the cycle a new frame is being latched
module column_scan_driver #(
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [34:0] frame,
    output logic [4:0]  L,
    output logic [6:0]  C,
    output logic [2:0]  col_idx,
    output logic        frame_start
);

    localparam int PMAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0] ON_LAST = PW'(DIV - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, LOAD, ON, BLANK} state_t;

    state_t      state, state_next;
    logic [2:0]  col_next;
    logic [PW-1:0] phase, phase_next;
    logic [34:0] buffer, buffer_next;
    logic [4:0]  l_next;
    logic [6:0]  c_next;
    logic        fs_next;
    logic        advance;

    // State register: FSM state, phase counter, column counter and frame buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            col_idx <= '0;
            buffer  <= '0;
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            col_idx <= col_next;
            buffer  <= buffer_next;
        end
    end

    // Next-state logic. Dropping enable overrides everything, so a restart
    // always begins with a fresh LOAD at column 0.
    always_comb begin
        state_next = state;
        col_next   = col_idx;
        phase_next = phase + 1'b1;
        advance    = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            col_next   = '0;
            phase_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = LOAD;
                    col_next   = '0;
                    phase_next = '0;
                end
                LOAD: begin
                    state_next = ON;
                    col_next   = '0;
                    phase_next = '0;
                end
                ON: begin
                    if (phase == ON_LAST) begin
`ifdef SCAN_BLANK_EN
                        state_next = BLANK;
                        phase_next = '0;
`else
                        advance = 1'b1;
`endif
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (phase == BLANK_LAST) begin
                        advance = 1'b1;
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                    col_next   = '0;
                    phase_next = '0;
                end
            endcase
            // After the last column, wrap to LOAD so the next frame is relatched.
            if (advance) begin
                phase_next = '0;
                if (col_idx == 3'd6) begin
                    state_next = LOAD;
                    col_next   = '0;
                end else begin
                    state_next = ON;
                    col_next   = col_idx + 3'd1;
                end
            end
        end
    end

    // Output logic, computed from the upcoming state so that every output
    // is a flop yet changes on the same edge as the state itself. The
    // buffer is captured on the edge that leaves LOAD, and that edge
    // already presents column 0 of the new data.
    always_comb begin
        buffer_next = buffer;
        if (state == LOAD && enable) begin
            buffer_next = frame;
        end
        l_next  = '0;
        c_next  = '0;
        fs_next = (state_next == LOAD);
        if (state_next == ON) begin
            c_next = 7'(1) << col_next;
            for (int r = 0; r < 5; r++) begin
                l_next[r] = buffer_next[6'(r * 7) + {3'b000, col_next}];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            L           <= '0;
            C           <= '0;
            frame_start <= 1'b0;
        end else begin
            L           <= l_next;
            C           <= c_next;
            frame_start <= fs_next;
        end
    end

endmodule

// File: tb/tb_column_scan_driver.sv
// Testbench for column_scan_driver. The expected panel outputs are derived
// from the position within the frame period (time since frame_start), using
// plain arithmetic. A fixed vector table is checked, followed by hand
// sequences and a randomized run.
module tb_column_scan_driver;

    localparam int DIV = 4;
`ifdef SCAN_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int SPAN   = DIV + BL;
    localparam int PERIOD = 1 + 7 * SPAN;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [34:0] frame;
    logic [4:0]  L;
    logic [6:0]  C;
    logic [2:0]  col_idx;
    logic        frame_start;

    column_scan_driver #(.DIV(DIV), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame(frame),
        .L(L), .C(C), .col_idx(col_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Reference model: running flag, cycles since frame_start, latched frame.
    bit          running = 1'b0;
    int          t       = 0;
    logic [34:0] latched = '0;

    typedef struct {
        int         cyc;
        logic       fs;
        logic [6:0] c;
        logic [4:0] l;
        logic [2:0] col;
    } vec_t;
    vec_t tbl[11];

    task automatic check1(input string name, input int act, input int exp);
        nAssert++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] colBits(input logic [34:0] f, input int c);
        logic [4:0]  b;
        logic [34:0] s;
        for (int r = 0; r < 5; r++) begin
            s    = f >> (r * 7 + c);
            b[r] = s[0];
        end
        return b;
    endfunction

    function automatic logic [34:0] randFrame();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        return x[34:0];
    endfunction

    function automatic bit modelOnCol(input int c);
        return running && (t > 0) && ((t - 1) / SPAN == c) && ((t - 1) % SPAN < DIV);
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelStep(input logic en, input logic [34:0] fr);
        if (!en) begin
            running = 1'b0;
        end else if (!running) begin
            running = 1'b1;
            t       = 0;
        end else begin
            if (t == 0) latched = fr;
            t = (t + 1) % PERIOD;
        end
    endtask

    task automatic checkOutput(input string tag);
        int expL, expC, expCol, expFs, u, col;
        expL = 0; expC = 0; expCol = 0; expFs = 0;
        if (running) begin
            if (t == 0) begin
                expFs = 1;
            end else begin
                u      = t - 1;
                col    = u / SPAN;
                expCol = col;
                if (u % SPAN < DIV) begin
                    expC = 1 << col;
                    expL = int'(colBits(latched, col));
                end
            end
        end
        check1({tag, "_L"}, int'(L), expL);
        check1({tag, "_C"}, int'(C), expC);
        check1({tag, "_col"}, int'(col_idx), expCol);
        check1({tag, "_fs"}, int'(frame_start), expFs);
    endtask

    task automatic applyStimulus(input logic en, input logic [34:0] fr);
        enable = en;
        frame  = fr;
        @(posedge clk);
        modelStep(en, fr);
        @(negedge clk);
        checkOutput("model");
    endtask

    task automatic waitOn(input int c, input logic [34:0] fr);
        int k = 0;
        while (!modelOnCol(c) && k < 200) begin
            applyStimulus(1'b1, fr);
            k++;
        end
        if (k >= 200) begin
            nAssert++;
            nFail++;
            $display("[TB] FAIL wait_col%0d: timed out, column never lit", c);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [34:0] fr, a, b;

`ifdef SCAN_BLANK_EN
        tbl[0]  = '{1,  1'b1, 7'b0000000, 5'b00000, 3'd0};
        tbl[1]  = '{2,  1'b0, 7'b0000001, 5'b00000, 3'd0};
        tbl[2]  = '{6,  1'b0, 7'b0000000, 5'b00000, 3'd0};
        tbl[3]  = '{19, 1'b0, 7'b0000000, 5'b00000, 3'd2};
        tbl[4]  = '{20, 1'b0, 7'b0001000, 5'b10101, 3'd3};
        tbl[5]  = '{23, 1'b0, 7'b0001000, 5'b10101, 3'd3};
        tbl[6]  = '{24, 1'b0, 7'b0000000, 5'b00000, 3'd3};
        tbl[7]  = '{26, 1'b0, 7'b0010000, 5'b00000, 3'd4};
        tbl[8]  = '{43, 1'b0, 7'b0000000, 5'b00000, 3'd6};
        tbl[9]  = '{44, 1'b1, 7'b0000000, 5'b00000, 3'd0};
        tbl[10] = '{45, 1'b0, 7'b0000001, 5'b00000, 3'd0};
`else
        tbl[0]  = '{1,  1'b1, 7'b0000000, 5'b00000, 3'd0};
        tbl[1]  = '{2,  1'b0, 7'b0000001, 5'b00000, 3'd0};
        tbl[2]  = '{5,  1'b0, 7'b0000001, 5'b00000, 3'd0};
        tbl[3]  = '{6,  1'b0, 7'b0000010, 5'b00000, 3'd1};
        tbl[4]  = '{13, 1'b0, 7'b0000100, 5'b00000, 3'd2};
        tbl[5]  = '{14, 1'b0, 7'b0001000, 5'b10101, 3'd3};
        tbl[6]  = '{17, 1'b0, 7'b0001000, 5'b10101, 3'd3};
        tbl[7]  = '{18, 1'b0, 7'b0010000, 5'b00000, 3'd4};
        tbl[8]  = '{29, 1'b0, 7'b1000000, 5'b00000, 3'd6};
        tbl[9]  = '{30, 1'b1, 7'b0000000, 5'b00000, 3'd0};
        tbl[10] = '{31, 1'b0, 7'b0000001, 5'b00000, 3'd0};
`endif

        // Reset, then idle with enable low.
        rst = 1'b1; enable = 1'b0; frame = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst = 1'b0;
        repeat (100) applyStimulus(1'b0, randFrame());

        // Single lit column (column 3 = 5'b10101), checked against the table.
        fr = (35'(1) << 3) | (35'(1) << 17) | (35'(1) << 31);
        for (int n = 1; n <= 45; n++) begin
            applyStimulus(1'b1, fr);
            for (int i = 0; i < 11; i++) begin
                if (tbl[i].cyc == n) begin
                    check1($sformatf("tbl%0d_fs", i), int'(frame_start), int'(tbl[i].fs));
                    check1($sformatf("tbl%0d_C", i), int'(C), int'(tbl[i].c));
                    check1($sformatf("tbl%0d_L", i), int'(L), int'(tbl[i].l));
                    check1($sformatf("tbl%0d_col", i), int'(col_idx), int'(tbl[i].col));
                end
            end
        end
        applyStimulus(1'b0, fr);

        // Double buffering: frame changes during column 2 stay hidden until the next frame.
        a = randFrame();
        b = ~a;
        applyStimulus(1'b1, a);
        waitOn(2, a);
        applyStimulus(1'b1, b);
        waitOn(3, b);
        check1("dbuf_old", int'(L), int'(colBits(a, 3)));
        waitOn(0, b);
        check1("dbuf_new", int'(L), int'(colBits(b, 0)));

        // Enable dropped at column 4, then restarted from LOAD and column 0.
        waitOn(4, b);
        applyStimulus(1'b0, b);
        check1("drop_C", int'(C), 0);
        check1("drop_L", int'(L), 0);
        check1("drop_col", int'(col_idx), 0);
        applyStimulus(1'b1, b);
        check1("restart_fs", int'(frame_start), 1);
        applyStimulus(1'b1, b);
        check1("restart_C", int'(C), 1);
        check1("restart_col", int'(col_idx), 0);

        // Asynchronous reset in the middle of column 5.
        waitOn(5, b);
        #2 rst = 1'b1;
        #1;
        check1("arst_L", int'(L), 0);
        check1("arst_C", int'(C), 0);
        check1("arst_col", int'(col_idx), 0);
        check1("arst_fs", int'(frame_start), 0);
        running = 1'b0; t = 0; latched = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("arst_hold");
        rst = 1'b0;
        applyStimulus(1'b1, b);
        check1("arst_reload_fs", int'(frame_start), 1);

        // Randomized run: occasional enable drops and frame changes.
        fr = randFrame();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) fr = randFrame();
            applyStimulus($urandom_range(0, 63) != 0, fr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
